// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types for the decode-to-execute boundary stage.
//   id_ex_entry_t  - one buffered decoded instruction
//   id_ex_state_e  - occupancy of the two-entry skid buffer
//   REG_X0         - index of the hard-wired zero register
// The ID_* widths size the entry struct; the id_ex_buffer parameters must
// match them.
package id_ex_pkg;
  localparam int ID_DW  = 32;
  localparam int ID_OPW = 4;
  localparam int ID_AW  = 5;

  localparam logic [ID_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } id_ex_state_e;

  typedef struct packed {
    logic [ID_AW-1:0]  rs1;
    logic [ID_AW-1:0]  rs2;
    logic [ID_DW-1:0]  rs1_data;
    logic [ID_DW-1:0]  rs2_data;
    logic [ID_DW-1:0]  imm;
    logic              alu_src;
    logic [ID_OPW-1:0] operation;
    logic [ID_AW-1:0]  rd;
    logic              reg_write;
  } id_ex_entry_t;
endpackage

// File: rtl/wb_operand_bypass.sv
// wb_operand_bypass: combinational writeback match-and-select for one
// register operand.
//   rs, data              - operand register index and its current value
//   wb_en, wb_rd, wb_data - writeback port
//   q                     - wb_data when writeback targets rs (never x0),
//                           otherwise data
// With IDEX_WB_BYPASS_EN undefined the writeback port is ignored and q = data.
module wb_operand_bypass
  import id_ex_pkg::*;
#(
  parameter int DW = ID_DW,
  parameter int AW = ID_AW
) (
  input  logic [AW-1:0] rs,
  input  logic [DW-1:0] data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] q
);
`ifdef IDEX_WB_BYPASS_EN
  assign q = (wb_en && (wb_rd != AW'(REG_X0)) && (wb_rd == rs)) ? wb_data : data;
`else
  logic unused;
  assign unused = ^{rs, wb_en, wb_rd, wb_data};
  assign q      = data;
`endif
endmodule

// File: rtl/id_ex_buffer.sv
// id_ex_buffer: decode-to-execute skid buffer (two entries) feeding the ALU.
//   clk, rst_n (sync, active-low)
//   in_*        - decoded instruction + valid/ready handshake from decode
//   flush       - drop all buffered and incoming instructions
//   out_valid/out_ready, SrcA, SrcB, Operation, out_rd, out_reg_write - to EX
//   wb_en/wb_rd/wb_data - writeback port kept coherent with buffered operands
// Optional feature macro: IDEX_WB_BYPASS_EN (capture/snoop/output bypass).
module id_ex_buffer
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  in_operation,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_reg_write,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data
);
  id_ex_state_e state_q, state_d;
  id_ex_entry_t head_q, head_d, skid_q, skid_d;
  id_ex_entry_t cap, head_snp, skid_snp;

  logic accept, pop;
  logic [DATA_WIDTH-1:0] cap_d1, cap_d2, hs_d1, hs_d2, ss_d1, ss_d2, srca_byp, srcb_byp;

  // Handshake flags depend only on state (and reset), never on out_ready.
  assign in_ready  = rst_n && (state_q != FULL);
  assign out_valid = rst_n && (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Capture: same-cycle writeback overrides stale register-file read data.
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_cap1 (.rs(in_rs1), .data(in_rs1_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(cap_d1));
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_cap2 (.rs(in_rs2), .data(in_rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(cap_d2));
  // Snoop: stored entries pick up writebacks while they wait.
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_hs1 (.rs(head_q.rs1), .data(head_q.rs1_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(hs_d1));
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_hs2 (.rs(head_q.rs2), .data(head_q.rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(hs_d2));
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_ss1 (.rs(skid_q.rs1), .data(skid_q.rs1_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(ss_d1));
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_ss2 (.rs(skid_q.rs2), .data(skid_q.rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(ss_d2));
  // Output: the ALU sees a writeback to the head's sources in the same cycle.
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_out1 (.rs(head_q.rs1), .data(head_q.rs1_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(srca_byp));
  wb_operand_bypass #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_out2 (.rs(head_q.rs2), .data(head_q.rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q(srcb_byp));

  always_comb begin
    cap           = '0;
    cap.rs1       = in_rs1;
    cap.rs2       = in_rs2;
    cap.rs1_data  = cap_d1;
    cap.rs2_data  = cap_d2;
    cap.imm       = in_imm;
    cap.alu_src   = in_alu_src;
    cap.operation = in_operation;
    cap.rd        = in_rd;
    cap.reg_write = in_reg_write;
    head_snp          = head_q;
    head_snp.rs1_data = hs_d1;
    head_snp.rs2_data = hs_d2;
    skid_snp          = skid_q;
    skid_snp.rs1_data = ss_d1;
    skid_snp.rs2_data = ss_d2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_snp;
    skid_d  = skid_snp;
    if (flush) begin
      // A same-cycle pop already completed on the current outputs.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          head_d  = cap;
          state_d = ONE;
        end
        ONE: begin
          if (accept && pop) head_d = cap;
          else if (accept) begin
            skid_d  = cap;
            state_d = FULL;
          end else if (pop) state_d = EMPTY;
        end
        FULL: if (pop) begin
          head_d  = skid_snp;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign SrcA          = out_valid ? srca_byp : '0;
  assign SrcB          = out_valid ? (head_q.alu_src ? head_q.imm : srcb_byp) : '0;
  assign Operation     = out_valid ? head_q.operation : '0;
  assign out_rd        = out_valid ? head_q.rd : '0;
  assign out_reg_write = out_valid && head_q.reg_write;
endmodule

// File: tb/tb_id_ex_buffer.sv
// tb_id_ex_buffer: directed table-driven bench for id_ex_buffer, plus a
// hand-written back-to-back streaming sequence.
module tb_id_ex_buffer;
`ifdef IDEX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, in_alu_src, in_reg_write, flush;
  logic out_valid, out_ready, out_reg_write, wb_en;
  logic [4:0] in_rs1, in_rs2, in_rd, out_rd, wb_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, SrcA, SrcB, wb_data;
  logic [3:0] in_operation, Operation;

  id_ex_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src), .in_operation(in_operation), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct packed {
    logic [4:0]  rs1;
    logic [31:0] d1;
    logic [4:0]  rs2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        src;
    logic [3:0]  op;
    logic [4:0]  rd;
  } ins_t;

  typedef struct {
    string       name;
    logic        rst, iv;
    ins_t        ins;
    logic        fl, ord, wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        ir, ov;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
  } vec_t;

  function automatic vec_t v(string n, logic rst, logic iv, ins_t i, logic fl, logic ord,
                             logic wbe, logic [4:0] wbrd, logic [31:0] wbd, logic ir, logic ov,
                             logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [4:0] rd, logic rw);
    vec_t r;
    r.name = n; r.rst = rst; r.iv = iv; r.ins = i; r.fl = fl; r.ord = ord; r.wbe = wbe;
    r.wbrd = wbrd; r.wbd = wbd; r.ir = ir; r.ov = ov; r.a = a; r.b = b; r.op = op; r.rd = rd; r.rw = rw;
    return r;
  endfunction

  int checks = 0;
  int passed = 0;

  task automatic drive(input logic rst, input logic iv, input ins_t i, input logic fl, input logic ord,
                       input logic wbe, input logic [4:0] wbrd, input logic [31:0] wbd);
    rst_n = rst; in_valid = iv; flush = fl; out_ready = ord;
    in_rs1 = i.rs1; in_rs1_data = i.d1; in_rs2 = i.rs2; in_rs2_data = i.d2;
    in_imm = i.imm; in_alu_src = i.src; in_operation = i.op; in_rd = i.rd;
    in_reg_write = (i.rd != 5'd0);
    wb_en = wbe; wb_rd = wbrd; wb_data = wbd;
  endtask

  task automatic check(input string name, input logic [75:0] got, input logic [75:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  vec_t vecs[$];
  ins_t N, A1, A2, A3, S1, Z, F, si;

  initial begin
    N  = '0;
    A1 = '{rs1: 5'd1,  d1: 32'h11, rs2: 5'd2,  d2: 32'h22, imm: 32'h0,          src: 1'b0, op: 4'b0010, rd: 5'd3};
    A2 = '{rs1: 5'd4,  d1: 32'h44, rs2: 5'd6,  d2: 32'h66, imm: 32'h0,          src: 1'b0, op: 4'b0010, rd: 5'd7};
    A3 = '{rs1: 5'd8,  d1: 32'h88, rs2: 5'd9,  d2: 32'h99, imm: 32'h0,          src: 1'b0, op: 4'b0010, rd: 5'd10};
    S1 = '{rs1: 5'd5,  d1: 32'h10, rs2: 5'd6,  d2: 32'h60, imm: 32'h0,          src: 1'b0, op: 4'b0000, rd: 5'd11};
    Z  = '{rs1: 5'd0,  d1: 32'h0,  rs2: 5'd0,  d2: 32'h7,  imm: 32'hFFFF_FFFC,  src: 1'b1, op: 4'b0010, rd: 5'd0};
    F  = '{rs1: 5'd12, d1: 32'hC0, rs2: 5'd13, d2: 32'hD0, imm: 32'h5,          src: 1'b1, op: 4'b0110, rd: 5'd14};

    //                    name        rst iv ins fl ord wbe wbrd  wbd              ir ov  a         b               op     rd     rw
    vecs.push_back(v("rst_low",      0, 0, N,  0, 0, 0, 5'd0, 32'h0,            0, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("rst_release",  1, 0, N,  0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("str_acc1",     1, 1, A1, 0, 1, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("str_out1",     1, 1, A2, 0, 1, 0, 5'd0, 32'h0,            1, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("str_out2",     1, 1, A3, 0, 1, 0, 5'd0, 32'h0,            1, 1, 32'h44, 32'h66,         4'd2, 5'd7,  1));
    vecs.push_back(v("str_out3",     1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 1, 32'h88, 32'h99,         4'd2, 5'd10, 1));
    vecs.push_back(v("str_empty",    1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("stl_acc1",     1, 1, A1, 0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("stl_acc2",     1, 1, A2, 0, 0, 0, 5'd0, 32'h0,            1, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("stl_full",     1, 1, A3, 0, 0, 0, 5'd0, 32'h0,            0, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("stl_held",     1, 1, A3, 0, 0, 0, 5'd0, 32'h0,            0, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("stl_pop1",     1, 0, N,  0, 1, 0, 5'd0, 32'h0,            0, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("stl_pop2",     1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 1, 32'h44, 32'h66,         4'd2, 5'd7,  1));
    vecs.push_back(v("stl_empty",    1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("snp_acc",      1, 1, S1, 0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("snp_before",   1, 0, N,  0, 0, 0, 5'd0, 32'h0,            1, 1, 32'h10, 32'h60,         4'd0, 5'd11, 1));
    vecs.push_back(v("snp_bypass",   1, 0, N,  0, 0, 1, 5'd5, 32'hABCD,         1, 1, BYP ? 32'hABCD : 32'h10, 32'h60, 4'd0, 5'd11, 1));
    vecs.push_back(v("snp_stored",   1, 0, N,  0, 0, 0, 5'd0, 32'h0,            1, 1, BYP ? 32'hABCD : 32'h10, 32'h60, 4'd0, 5'd11, 1));
    vecs.push_back(v("snp_pop",      1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 1, BYP ? 32'hABCD : 32'h10, 32'h60, 4'd0, 5'd11, 1));
    vecs.push_back(v("cap_acc",      1, 1, S1, 0, 0, 1, 5'd6, 32'h1234,         1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("cap_out",      1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 1, 32'h10, BYP ? 32'h1234 : 32'h60, 4'd0, 5'd11, 1));
    vecs.push_back(v("x0_acc",       1, 1, Z,  0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("x0_wb",        1, 0, N,  0, 0, 1, 5'd0, 32'hFFFF_FFFF,    1, 1, 32'h0,  32'hFFFF_FFFC,  4'd2, 5'd0,  0));
    vecs.push_back(v("x0_pop",       1, 0, N,  0, 1, 1, 5'd0, 32'hFFFF_FFFF,    1, 1, 32'h0,  32'hFFFF_FFFC,  4'd2, 5'd0,  0));
    vecs.push_back(v("fl_acc1",      1, 1, A1, 0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("fl_acc2",      1, 1, A2, 0, 0, 0, 5'd0, 32'h0,            1, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("fl_full",      1, 1, F,  1, 0, 0, 5'd0, 32'h0,            0, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("fl_empty",     1, 0, N,  0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("fl1_acc",      1, 1, A3, 0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("fl1_pop_drop", 1, 1, F,  1, 1, 0, 5'd0, 32'h0,            1, 1, 32'h88, 32'h99,         4'd2, 5'd10, 1));
    vecs.push_back(v("fl1_empty",    1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("rs_acc1",      1, 1, A1, 0, 0, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("rs_acc2",      1, 1, A2, 0, 0, 0, 5'd0, 32'h0,            1, 1, 32'h11, 32'h22,         4'd2, 5'd3,  1));
    vecs.push_back(v("rs_low_full",  0, 0, N,  0, 1, 0, 5'd0, 32'h0,            0, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("rs_after",     1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("rs_acc3",      1, 1, A3, 0, 1, 0, 5'd0, 32'h0,            1, 0, 32'h0,  32'h0,          4'd0, 5'd0,  0));
    vecs.push_back(v("rs_out3",      1, 0, N,  0, 1, 0, 5'd0, 32'h0,            1, 1, 32'h88, 32'h99,         4'd2, 5'd10, 1));

    drive(1'b0, 1'b0, N, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].iv, vecs[k].ins, vecs[k].fl, vecs[k].ord, vecs[k].wbe, vecs[k].wbrd, vecs[k].wbd);
      #1;
      check(vecs[k].name,
            {in_ready, out_valid, SrcA, SrcB, Operation, out_rd, out_reg_write},
            {vecs[k].ir, vecs[k].ov, vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].rd, vecs[k].rw});
    end

    // Back-to-back stream: each instruction must appear the cycle after its
    // accept, with in_ready never dropping; odd ones take the immediate.
    for (int k = 0; k <= 6; k++) begin
      logic [31:0] ea, eb;
      @(negedge clk);
      si = '{rs1: 5'(k + 1), d1: 32'h1000 + 32'(k), rs2: 5'(k + 16), d2: 32'h2000 + 32'(k),
             imm: 32'h500 + 32'(k), src: k[0], op: 4'(k), rd: 5'(k + 20)};
      drive(1'b1, (k < 6), si, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      if (k > 0) begin
        ea = 32'h1000 + 32'(k - 1);
        eb = ((k - 1) % 2 == 1) ? 32'h500 + 32'(k - 1) : 32'h2000 + 32'(k - 1);
        check($sformatf("stream%0d", k - 1), {in_ready, out_valid, SrcA, SrcB, Operation, out_rd, out_reg_write},
              {1'b1, 1'b1, ea, eb, 4'(k - 1), 5'(k + 19), 1'b1});
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b0, N, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    check("stream_drain", {in_ready, out_valid, SrcA, SrcB, Operation, out_rd, out_reg_write}, {2'b10, 74'h0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_buffer.md
# id_ex_buffer

Decode-to-execute boundary stage that feeds the ALU its `SrcA`, `SrcB` and `Operation` inputs. It holds up to two decoded instructions in a skid buffer with a valid/ready handshake, and selects the immediate or register operand for `SrcB`. It also keeps buffered register operands coherent with the writeback port, so a stall never delivers stale data to the ALU.

## Interface
- `DATA_WIDTH`, 32, operand and result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR_WIDTH`, 5, register index width
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `in_valid`  in  1  decode offers an instruction
- `in_ready`  out  1  buffer can accept this cycle
- `in_rs1`, `in_rs2`  in  REG_ADDR_WIDTH  source register indices
- `in_rs1_data`, `in_rs2_data`  in  DATA_WIDTH  register-file read data
- `in_imm`  in  DATA_WIDTH  sign-extended immediate
- `in_alu_src`  in  1  1 selects `in_imm` for `SrcB`
- `in_operation`  in  OPCODE_LENGTH  ALU operation code
- `in_rd`  in  REG_ADDR_WIDTH  destination register
- `in_reg_write`  in  1  instruction writes `rd`
- `flush`  in  1  discard all buffered and incoming instructions
- `out_valid`  out  1  head entry presented to the ALU
- `out_ready`  in  1  execute consumes the head entry
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU operation code
- `out_rd`  out  REG_ADDR_WIDTH  destination of the head entry
- `out_reg_write`  out  1  write enable of the head entry
- `wb_en`  in  1  writeback is active this cycle
- `wb_rd`  in  REG_ADDR_WIDTH  writeback register index
- `wb_data`  in  DATA_WIDTH  writeback data

## Operation
**Handshake**
- accept = `in_valid & in_ready`.
- pop = `out_valid & out_ready`.
- `in_ready` = state != FULL. It depends only on state, with no combinational path from `out_ready`.

**State machine** (EMPTY, ONE, FULL)
- EMPTY: accept → ONE.
- ONE:
  - accept without pop → FULL.
  - pop without accept → EMPTY.
  - accept and pop together → ONE; the new entry becomes the head.
- FULL: pop → ONE; the skid entry moves to the head.

**Flush**
- `flush` = 1 has priority over all other events. Next state is EMPTY.
- An accept in the same cycle is dropped.
- A pop in the same cycle still completes on the current output.

**Entry contents**
- Stored fields: rs1, rs2, rs1_data, rs2_data, imm, alu_src, operation, rd, reg_write.

**Writeback matching**
- A match means `wb_en` = 1, `wb_rd` != 0, and `wb_rd` equals the rs field.
- Capture: on accept, a matching rs has `wb_data` stored instead of `in_rsN_data`.
- Snoop: each cycle, every stored entry with a matching rs field has that data field overwritten with `wb_data`.
- Output bypass: if the head's rs1 matches this cycle, `SrcA` = `wb_data`. The rs2 path is treated the same before the `SrcB` mux.

**Outputs**
- `SrcA` = rs1 value after bypass.
- `SrcB` = alu_src ? imm : rs2 value after bypass.
- `Operation`, `out_rd`, `out_reg_write` come from the head entry.
- When `out_valid` = 0, `SrcA`, `SrcB`, `Operation`, `out_rd` and `out_reg_write` are all driven 0.

**Register x0**
- Index 0 never matches writeback, so x0 data is never overwritten.

## Timing
- Latency: an instruction accepted at edge N is presented with `out_valid` = 1 in the cycle after edge N. There is no combinational `in_*` → `out_*` path.
- Throughput: one instruction per cycle when `out_ready` is held at 1.
- Reset: while `rst_n` = 0 at the edge, the next state is EMPTY.
  - `out_valid` = 0 and `in_ready` = 0 for the whole cycle in which `rst_n` is low.
  - All data outputs are 0 after reset; `in_ready` = 1 on the first cycle after reset.
- Reset mid-transfer: buffered entries are lost and no pop is reported.
- `out_valid` and the head data stay stable until popped. The one exception is a change caused by writeback bypass or snoop of the head's registers.

## Configuration
- Macro `IDEX_WB_BYPASS_EN`.
- Defined: capture bypass, snoop and output bypass are implemented as described above.
- Undefined: stored data comes only from `in_rsN_data`. The `wb_*` ports remain present but are ignored.

## Structure
- Package `id_ex_pkg` holds:
  - `id_ex_entry_t`, a packed struct of the stored fields;
  - `id_ex_state_e` for EMPTY/ONE/FULL;
  - the x0 index constant.
- One sub-module, `wb_operand_bypass`: a combinational match-and-select of (rs, data, wb_en, wb_rd, wb_data) → data. It is instantiated for capture, snoop and output.

## Test plan
1. **Streaming:** stream 3 ADDs (`in_operation` 4'b0010) with `out_ready`=1. Expect `out_valid` one cycle after each accept, in order, with `in_ready` held at 1.
2. **Stall and fill:** hold `out_ready`=0 and offer 3 instructions. Expect 2 accepted, `in_ready`=0 in FULL, and the third held. Then release: order is preserved and the state passes ONE → EMPTY.
3. **Snoop:** buffer an entry with rs1=5 and rs1_data=0x10, stalled. Pulse `wb_en` with `wb_rd`=5 and `wb_data`=0xABCD. Expect `SrcA`=0xABCD on that cycle and after.
4. **x0 and immediate:** `wb_rd`=0 with `wb_data`=0xFFFF_FFFF and entry rs1=0, rs1_data=0 → `SrcA` stays 0. With `in_alu_src`=1 and `in_imm`=0xFFFF_FFFC → `SrcB`=0xFFFF_FFFC.
5. **Flush:** `flush` in FULL together with `in_valid`=1. The next cycle shows `out_valid`=0, EMPTY state, and the offered instruction is never output.
6. **Reset:** `rst_n`=0 in FULL. Expect `out_valid`=0 and `in_ready`=0 during reset. After release: `in_ready`=1 and all data outputs are 0.
